tcam_match_scanner: RTL and testbench

- Consumes the one-hot-per-entry search result of the TCAM and turns it into a serial stream of matching entry addresses.
- Captures a match vector together with the entry-valid vector on a `start` strobe, masks one with the other, then emits every matching address in ascending order.
- Output uses a valid/ready handshake, plus a match count and hit flag.
- Sits between the TCAM's `match` / `is_data_valid` outputs and the lookup logic that reads back matched entries.

---
 rtl/tcam_match_scanner_if.sv | 24 ++
 rtl/tcam_match_scanner.sv | 63 ++++++
 tb/tb_tcam_match_scanner.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/tcam_match_scanner_if.sv
// tcam_match_scanner_if: capture request and matched-address stream between TCAM result and lookup logic.
interface tcam_match_scanner_if #(parameter int number_of_address_lines = 3);
    localparam int addr_w = number_of_address_lines;
    localparam int entries = 1 << number_of_address_lines;
    logic start;
    logic [entries-1:0] match_in;
    logic [entries-1:0] valid_in;
    logic out_ready;
    logic out_valid;
    logic [addr_w-1:0] out_addr;
    logic out_last;
    logic hit;
    logic [addr_w:0] match_count;
    logic busy;
    logic done;
    modport master(
        output start, match_in, valid_in, out_ready,
        input out_valid, out_addr, out_last, hit, match_count, busy, done
    );
    modport slave(
        input start, match_in, valid_in, out_ready,
        output out_valid, out_addr, out_last, hit, match_count, busy, done
    );
endinterface

// File: rtl/tcam_match_scanner.sv
// tcam_match_scanner: captures a masked TCAM match vector and streams matching entry addresses in ascending order.
module tcam_match_scanner #(
    parameter int number_of_address_lines = 3
) (
    input logic clk,
    input logic reset,
    tcam_match_scanner_if.slave bus
);
    localparam int addr_w = number_of_address_lines;
    localparam int entries = 1 << number_of_address_lines;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t state;
    logic [entries-1:0] pending;
    logic [entries-1:0] masked;
    logic [entries-1:0] rest;
    logic [addr_w:0] pop;
    logic [addr_w-1:0] lsb;
    logic hit_q;
    logic [addr_w:0] count_q;

    always_comb begin
        masked = bus.match_in & bus.valid_in;
        rest = pending & (pending - 1'b1);
        pop = '0;
        for (int i = 0; i < entries; i++) pop = pop + (addr_w + 1)'(masked[i]);
        lsb = '0;
        for (int i = entries - 1; i >= 0; i--) if (pending[i]) lsb = addr_w'(i);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            pending <= '0;
            hit_q <= 1'b0;
            count_q <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    pending <= masked;
                    count_q <= pop;
                    hit_q <= |masked;
                    state <= |masked ? SCAN : DONE;
                end
                SCAN: if (bus.out_ready) begin
                    pending <= rest;
                    state <= rest == '0 ? DONE : SCAN;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Every output decodes registered state only, so capture inputs never reach them combinationally.
    assign bus.out_valid = state == SCAN;
    assign bus.out_addr = state == SCAN ? lsb : '0;
    assign bus.out_last = state == SCAN && rest == '0;
    assign bus.hit = hit_q;
    assign bus.match_count = count_q;
    assign bus.busy = state != IDLE;
    assign bus.done = state == DONE;
endmodule

// File: tb/tb_tcam_match_scanner.sv
// tb_tcam_match_scanner: directed stimulus with a queue scoreboard checked by an independent output monitor.
module tb_tcam_match_scanner;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int fails = 0;
    logic [3:0] exp_q[$];

    tcam_match_scanner_if #(3) bus();

    tcam_match_scanner #(.number_of_address_lines(3)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [7:0] m, input logic [7:0] v);
        bus.start = 1'b1;
        bus.match_in = m;
        bus.valid_in = v;
        step();
        bus.start = 1'b0;
    endtask

    // Expected entries are {last, addr}; the head is compared whenever an address is presented.
    always @(negedge clk) begin
        if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                check("out_addr", int'(bus.out_addr), int'(exp_q[0][2:0]));
                check("out_last", int'(bus.out_last), int'(exp_q[0][3]));
                if (bus.out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        bus.start = 1'b1;
        bus.match_in = 8'hFF;
        bus.valid_in = 8'hFF;
        bus.out_ready = 1'b1;
        step();
        step();
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_addr", int'(bus.out_addr), 0);
        check("rst_out_last", int'(bus.out_last), 0);
        check("rst_hit", int'(bus.hit), 0);
        check("rst_match_count", int'(bus.match_count), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        reset = 1'b0;
        bus.start = 1'b0;
        step();
        check("post_rst_busy", int'(bus.busy), 0);

        exp_q.push_back({1'b0, 3'd2});
        exp_q.push_back({1'b0, 3'd5});
        exp_q.push_back({1'b1, 3'd7});
        launch(8'b1010_0100, 8'hFF);
        check("t2_busy", int'(bus.busy), 1);
        check("t2_hit", int'(bus.hit), 1);
        check("t2_match_count", int'(bus.match_count), 3);
        step();
        step();
        check("t2_done_early", int'(bus.done), 0);
        step();
        check("t2_done", int'(bus.done), 1);
        step();
        check("t2_busy_end", int'(bus.busy), 0);
        check("t2_done_end", int'(bus.done), 0);
        check("t2_queue_empty", exp_q.size(), 0);

        exp_q.push_back({1'b1, 3'd0});
        launch(8'h81, 8'h01);
        check("t3_hit", int'(bus.hit), 1);
        check("t3_match_count", int'(bus.match_count), 1);
        step();
        check("t3_done", int'(bus.done), 1);
        step();
        check("t3_queue_empty", exp_q.size(), 0);

        launch(8'h3C, 8'hC3);
        check("t4_hit", int'(bus.hit), 0);
        check("t4_match_count", int'(bus.match_count), 0);
        check("t4_done", int'(bus.done), 1);
        check("t4_out_valid", int'(bus.out_valid), 0);
        step();
        check("t4_busy_end", int'(bus.busy), 0);

        exp_q.push_back({1'b0, 3'd1});
        exp_q.push_back({1'b1, 3'd4});
        bus.out_ready = 1'b0;
        launch(8'h12, 8'hFF);
        bus.start = 1'b1;
        bus.match_in = 8'hFF;
        step();
        bus.start = 1'b0;
        step();
        step();
        bus.out_ready = 1'b1;
        check("t5_stall_count", int'(bus.match_count), 2);
        step();
        check("t5_last_count", int'(bus.match_count), 2);
        step();
        check("t5_done", int'(bus.done), 1);
        check("t5_match_count", int'(bus.match_count), 2);
        step();
        check("t5_queue_empty", exp_q.size(), 0);

        exp_q.push_back({1'b0, 3'd0});
        exp_q.push_back({1'b0, 3'd1});
        exp_q.push_back({1'b0, 3'd2});
        launch(8'hFF, 8'hFF);
        step();
        step();
        bus.out_ready = 1'b0;
        reset = 1'b1;
        step();
        exp_q.delete();
        check("t6_out_valid", int'(bus.out_valid), 0);
        check("t6_out_addr", int'(bus.out_addr), 0);
        check("t6_hit", int'(bus.hit), 0);
        check("t6_match_count", int'(bus.match_count), 0);
        check("t6_busy", int'(bus.busy), 0);
        check("t6_done", int'(bus.done), 0);
        reset = 1'b0;
        bus.out_ready = 1'b1;
        exp_q.push_back({1'b1, 3'd6});
        launch(8'h40, 8'hFF);
        check("t6_new_count", int'(bus.match_count), 1);
        step();
        check("t6_new_done", int'(bus.done), 1);
        step();
        check("t6_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
